// File: rtl/mul_recon.sv
// mul_recon: rebuilds a dividend from quotient, divisor and remainder using an N-cycle shift-add.
// Errors short-circuit straight to DONE. done is registered one cycle behind the DONE state.
module mul_recon #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   quotient,
   input  logic [N-1:0]   divisor,
   input  logic [N-1:0]   remainder,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] result,
   output logic [N-1:0]   dividend,
   output logic           overflow,
   output logic           error_div,
   output logic           error_rem
);
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t         state, nxt;
   logic [2*N-1:0] acc, d_sh, acc_nxt;
   logic [N-1:0]   q_sh;
   logic [CW-1:0]  cnt;
   logic           bad_div, bad_rem, last;
   always_comb begin
      bad_div = divisor == '0;
      bad_rem = !bad_div && remainder >= divisor;
      acc_nxt = acc + (q_sh[0] ? d_sh : '0);
      last    = cnt == CW'(N - 1);
      nxt     = state == IDLE ? (start ? ((bad_div || bad_rem) ? DONE : RUN) : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
   end
   assign busy     = state != IDLE;
   assign dividend = result[N-1:0];
   // Divisor is pre-shifted and quotient consumed LSB first, so no variable shifter is needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         d_sh      <= '0;
         q_sh      <= '0;
         cnt       <= '0;
         done      <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         error_div <= 1'b0;
         error_rem <= 1'b0;
      end else begin
         state <= nxt;
         done  <= state == DONE;
         if (state == IDLE && start) begin
            acc  <= {{N{1'b0}}, remainder};
            d_sh <= {{N{1'b0}}, divisor};
            q_sh <= quotient;
            cnt  <= '0;
            if (bad_div || bad_rem) begin
               result    <= '0;
               overflow  <= 1'b0;
               error_div <= bad_div;
               error_rem <= bad_rem;
            end
         end else if (state == RUN) begin
            acc  <= acc_nxt;
            d_sh <= d_sh << 1;
            q_sh <= q_sh >> 1;
            cnt  <= cnt + CW'(1);
            if (last) begin
               result    <= acc_nxt;
               overflow  <= |acc_nxt[2*N-1:N];
               error_div <= 1'b0;
               error_rem <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_mul_recon.sv
// tb_mul_recon: randomized and directed checks of mul_recon against an arithmetic reference.
module tb_mul_recon;
   localparam int N = 4;
   logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [N-1:0]   quotient = '0, divisor = '0, remainder = '0;
   logic           busy, done, overflow, error_div, error_rem;
   logic [2*N-1:0] result;
   logic [N-1:0]   dividend;
   int             n_cmp = 0, n_bad = 0;
   mul_recon #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .quotient(quotient), .divisor(divisor),
      .remainder(remainder), .busy(busy), .done(done), .result(result), .dividend(dividend),
      .overflow(overflow), .error_div(error_div), .error_rem(error_rem)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_dividend"}, dividend, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_ediv"}, error_div, 0);
      check({tag, "_erem"}, error_rem, 0);
   endtask
   // Inputs and start are scrambled while the operation runs; the result must follow the latched triple.
   task automatic run_op(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r);
      int  exp_res, exp_lat, lat;
      bit  e_div, e_rem, seen;
      e_div   = d == 0;
      e_rem   = !e_div && r >= d;
      exp_res = (e_div || e_rem) ? 0 : int'(q) * int'(d) + int'(r);
      exp_lat = (e_div || e_rem) ? 1 : N + 1;
      @(negedge clk);
      quotient = q; divisor = d; remainder = r; start = 1'b1;
      @(negedge clk);
      check("busy_after_start", busy, 1);
      lat  = 0;
      seen = 0;
      while (!seen && lat < 20) begin
         quotient  = N'($urandom);
         divisor   = N'($urandom);
         remainder = N'($urandom);
         start     = 1'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) seen = 1;
         else check("busy_during_op", busy, 1);
      end
      start = 1'b0;
      check("done_seen", seen, 1);
      check("latency", lat, exp_lat);
      check("result", result, exp_res);
      check("dividend", dividend, exp_res % (1 << N));
      check("overflow", overflow, exp_res > (1 << N) - 1);
      check("error_div", error_div, e_div);
      check("error_rem", error_rem, e_rem);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      check("result_hold", result, exp_res);
   endtask
   initial begin
      int ndone;
      start = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_beats_start", busy, 0);
      run_op(4'd2, 4'd3, 4'd1);
      run_op(4'd15, 4'd15, 4'd14);
      run_op(4'd5, 4'd0, 4'd0);
      run_op(4'd2, 4'd3, 4'd3);
      run_op(4'd3, 4'd5, 4'd2);
      run_op(4'd0, 4'd7, 4'd6);
      @(negedge clk);
      quotient = 4'd15; divisor = 4'd15; remainder = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("abort");
      rst   = 1'b0;
      ndone = 0;
      repeat (N + 4) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_op(4'd6, 4'd9, 4'd4);
      repeat (40) run_op(N'($urandom), N'($urandom), N'($urandom));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mul_recon.md
MUL_RECON -- requirements
Module: mul_recon

Interface
REQ-001 The block SHALL take parameter N, default 4, as the operand width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a reconstruction; sampled only in IDLE.
REQ-005 quotient  input  N  unsigned quotient operand.
REQ-006 divisor  input  N  unsigned divisor operand.
REQ-007 remainder  input  N  unsigned remainder operand.
REQ-008 busy  output  1  high while a request is in progress, from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse when the result outputs are valid.
REQ-010 result  output  2N  full reconstructed dividend, quotient*divisor + remainder.
REQ-011 dividend  output  N  result[N-1:0].
REQ-012 overflow  output  1  result exceeds 2^N-1; the dividend does not fit in N bits.
REQ-013 error_div  output  1  divisor was zero.
REQ-014 error_rem  output  1  remainder >= divisor with divisor nonzero; the triple is not a valid division.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 IDLE with start=1: operands SHALL be latched into internal registers; next state RUN, or DONE if divisor==0 or remainder>=divisor.
REQ-017 IDLE with start=0: the FSM SHALL remain in IDLE and hold all outputs.
REQ-018 RUN SHALL last exactly N cycles; each cycle adds (divisor << i) to the accumulator when quotient bit i is set, LSB first, i = 0..N-1.
REQ-019 The accumulator SHALL be 2N bits, initialised to the zero-extended remainder at latch time; no intermediate truncation is allowed.
REQ-020 After the Nth RUN cycle the FSM SHALL enter DONE; DONE lasts one cycle, asserts done=1, then returns to IDLE.
REQ-021 Latency, valid path: start sampled at edge k; done=1 during the cycle following edge k+N+1.
REQ-022 Latency, error path: done=1 during the cycle following edge k+1.
REQ-023 result, dividend, overflow, error_div and error_rem SHALL be registered, update on entry to DONE, and hold until the next DONE.
REQ-024 overflow SHALL be 1 iff result[2N-1:N] != 0.
REQ-025 Error path: result=0, overflow=0, and exactly one of error_div or error_rem =1; error_div takes priority when divisor==0.
REQ-026 Valid path: error_div=0 and error_rem=0.
REQ-027 start while busy=1 or in DONE SHALL be ignored and not queued; input changes after latching SHALL NOT affect the result.
REQ-028 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-029 Maximum valid case, (2^N-1)*(2^N-1)+(2^N-2), SHALL fit in result with no wrap.

Reset
REQ-030 rst=1 at any clock edge SHALL force IDLE and clear the accumulator, busy, done, result, dividend, overflow, error_div and error_rem to 0.
REQ-031 rst SHALL take priority over start in the same cycle.
REQ-032 rst asserted during RUN or DONE SHALL abort the operation with no done pulse.

Verification
REQ-033 N=4, q=2, d=3, r=1, one-cycle start -> done after 5 cycles; result=7, dividend=7, overflow=0, errors=0.
REQ-034 N=4, q=15, d=15, r=14 -> result=239 (0xEF), dividend=0xF, overflow=1.
REQ-035 N=4, q=5, d=0, r=0 -> done 1 cycle after start; error_div=1, error_rem=0, result=0.
REQ-036 N=4, q=2, d=3, r=3 -> done 1 cycle after start; error_rem=1, result=0.
REQ-037 Start q=3, d=5, r=2, then change the inputs and pulse start at cycle 2 -> single done with result=17, overflow=1; no second operation.
REQ-038 Start, then rst=1 at RUN cycle 2 -> busy=0 and all outputs 0 the next cycle, no done pulse; a fresh start afterwards completes normally.
